// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: Set 2 scan codes to ASCII with shift tracking and an output FIFO; define PS2_SCANCODE_DECODER_CAPS_LOCK_EN for Caps Lock
module ps2_scancode_decoder #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] scanCode,
   input  logic       scanCodeReady,
   output logic [7:0] asciiChar,
   output logic       asciiValid,
   input  logic       asciiReady,
   output logic       shiftHeld,
   output logic       overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
   state_t state, state_nx;
   logic lshift, rshift, caps;
   logic make_en, brk_en, push, pop, accept, letter, upper;
   logic [8:0] lookup;
   logic [7:0] push_char;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;

   // Unshifted translation; bit 8 flags a printable key
   function automatic logic [8:0] map(input logic [7:0] c);
      case (c)
         8'h1C: map = {1'b1, 8'h61}; 8'h32: map = {1'b1, 8'h62}; 8'h21: map = {1'b1, 8'h63};
         8'h23: map = {1'b1, 8'h64}; 8'h24: map = {1'b1, 8'h65}; 8'h2B: map = {1'b1, 8'h66};
         8'h34: map = {1'b1, 8'h67}; 8'h33: map = {1'b1, 8'h68}; 8'h43: map = {1'b1, 8'h69};
         8'h3B: map = {1'b1, 8'h6A}; 8'h42: map = {1'b1, 8'h6B}; 8'h4B: map = {1'b1, 8'h6C};
         8'h3A: map = {1'b1, 8'h6D}; 8'h31: map = {1'b1, 8'h6E}; 8'h44: map = {1'b1, 8'h6F};
         8'h4D: map = {1'b1, 8'h70}; 8'h15: map = {1'b1, 8'h71}; 8'h2D: map = {1'b1, 8'h72};
         8'h1B: map = {1'b1, 8'h73}; 8'h2C: map = {1'b1, 8'h74}; 8'h3C: map = {1'b1, 8'h75};
         8'h2A: map = {1'b1, 8'h76}; 8'h1D: map = {1'b1, 8'h77}; 8'h22: map = {1'b1, 8'h78};
         8'h35: map = {1'b1, 8'h79}; 8'h1A: map = {1'b1, 8'h7A};
         8'h45: map = {1'b1, 8'h30}; 8'h16: map = {1'b1, 8'h31}; 8'h1E: map = {1'b1, 8'h32};
         8'h26: map = {1'b1, 8'h33}; 8'h25: map = {1'b1, 8'h34}; 8'h2E: map = {1'b1, 8'h35};
         8'h36: map = {1'b1, 8'h36}; 8'h3D: map = {1'b1, 8'h37}; 8'h3E: map = {1'b1, 8'h38};
         8'h46: map = {1'b1, 8'h39};
         8'h29: map = {1'b1, 8'h20}; 8'h5A: map = {1'b1, 8'h0D}; 8'h66: map = {1'b1, 8'h08};
         default: map = 9'h000;
      endcase
   endfunction

   // Prefix state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;

   // Prefix transitions on each consumed byte; E0 after a break prefix is just a code byte
   always_comb begin
      state_nx = !scanCodeReady ? state :
                 state == IDLE ? (scanCode == 8'hE0 ? EXT : scanCode == 8'hF0 ? BRK : IDLE) :
                 (state == EXT && scanCode == 8'hF0) ? EXT_BRK : IDLE;
   end

   // Classify the byte and form the character to queue
   always_comb begin
      make_en   = scanCodeReady && state == IDLE && scanCode != 8'hE0 && scanCode != 8'hF0;
      brk_en    = scanCodeReady && state == BRK;
      lookup    = map(scanCode);
      letter    = lookup[7:0] >= 8'h61 && lookup[7:0] <= 8'h7A;
      upper     = (lshift | rshift) ^ caps;
      push_char = (letter && upper) ? lookup[7:0] - 8'h20 : lookup[7:0];
      push      = make_en && lookup[8];
      pop       = asciiValid && asciiReady;
      accept    = push && (count != FULL || pop);
   end

   // Shift key flags: make sets, break clears
   always_ff @(posedge clk)
      if (rst) begin
         lshift <= 1'b0;
         rshift <= 1'b0;
      end else begin
         if ((make_en || brk_en) && scanCode == 8'h12) lshift <= make_en;
         if ((make_en || brk_en) && scanCode == 8'h59) rshift <= make_en;
      end

`ifdef PS2_SCANCODE_DECODER_CAPS_LOCK_EN
   // Caps Lock toggles on each make of 0x58
   always_ff @(posedge clk)
      caps <= rst ? 1'b0 : (make_en && scanCode == 8'h58) ? ~caps : caps;
`else
   assign caps = 1'b0;
`endif

   // FIFO storage, written at the tail on an accepted push
   always_ff @(posedge clk)
      if (accept) mem[wr_ptr] <= push_char;

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk)
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(accept) - (AW+1)'(pop);
         if (push && !accept) overflow <= 1'b1;
      end

   assign asciiValid = count != '0;
   assign asciiChar  = asciiValid ? mem[rd_ptr] : 8'h00;
   assign shiftHeld  = lshift | rshift;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed vectors with hand-computed expectations
module tb_ps2_scancode_decoder;
   localparam int DEPTH = 8;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] scanCode = 8'h00;
   logic       scanCodeReady = 1'b0;
   logic [7:0] asciiChar;
   logic       asciiValid;
   logic       asciiReady = 1'b0;
   logic       shiftHeld;
   logic       overflow;
   int vectors = 0;
   int miscompares = 0;

   ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .scanCode(scanCode), .scanCodeReady(scanCodeReady),
      .asciiChar(asciiChar), .asciiValid(asciiValid), .asciiReady(asciiReady),
      .shiftHeld(shiftHeld), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      scanCode = b;
      scanCodeReady = 1'b1;
      @(negedge clk);
      scanCodeReady = 1'b0;
   endtask

   task automatic pop();
      @(negedge clk);
      asciiReady = 1'b1;
      @(negedge clk);
      asciiReady = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_char"}, asciiChar, 8'h00);
      check({tag, "_valid"}, {7'b0, asciiValid}, 8'h00);
      check({tag, "_shift"}, {7'b0, shiftHeld}, 8'h00);
      check({tag, "_ovf"}, {7'b0, overflow}, 8'h00);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      check("pre_valid", {7'b0, asciiValid}, 8'h00);
      send(8'h1C);
      check("lat1_valid", {7'b0, asciiValid}, 8'h01);
      check("lat1_char", asciiChar, 8'h61);
      send(8'hF0);
      send(8'h1C);
      check("brk_char", asciiChar, 8'h61);
      pop();
      check("one_entry", {7'b0, asciiValid}, 8'h00);
      check("empty_char", asciiChar, 8'h00);

      send(8'h12);
      check("shift_on", {7'b0, shiftHeld}, 8'h01);
      send(8'h1C);
      send(8'hF0); send(8'h1C);
      send(8'hF0); send(8'h12);
      check("shift_off", {7'b0, shiftHeld}, 8'h00);
      send(8'h1C);
      check("upper_A", asciiChar, 8'h41);
      pop();
      check("lower_a", asciiChar, 8'h61);
      pop();
      check("shift_empty", {7'b0, asciiValid}, 8'h00);

      send(8'h59);
      check("rshift_on", {7'b0, shiftHeld}, 8'h01);
      send(8'h32); send(8'h16);
      send(8'hF0); send(8'h59);
      check("rshift_off", {7'b0, shiftHeld}, 8'h00);
      check("rshift_B", asciiChar, 8'h42);
      pop();
      check("digit_1", asciiChar, 8'h31);
      pop();

      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("ext_none", {7'b0, asciiValid}, 8'h00);
      send(8'h29);
      check("space", asciiChar, 8'h20);
      pop();
      check("ext_only", {7'b0, asciiValid}, 8'h00);
      send(8'hF0); send(8'hE0); send(8'h5A);
      check("enter", asciiChar, 8'h0D);
      pop();
      send(8'h66);
      check("bksp", asciiChar, 8'h08);
      pop();
      send(8'h77);
      check("unmapped", {7'b0, asciiValid}, 8'h00);

      for (int i = 0; i < DEPTH; i++) send(8'h16);
      check("full_no_ovf", {7'b0, overflow}, 8'h00);
      send(8'h16);
      check("ovf_set", {7'b0, overflow}, 8'h01);
      check("full_head", asciiChar, 8'h31);
      @(negedge clk);
      scanCode = 8'h1C;
      scanCodeReady = 1'b1;
      asciiReady = 1'b1;
      @(negedge clk);
      scanCodeReady = 1'b0;
      asciiReady = 1'b0;
      check("ovf_sticky", {7'b0, overflow}, 8'h01);
      for (int i = 0; i < DEPTH - 1; i++) begin
         check($sformatf("drain_%0d", i), asciiChar, 8'h31);
         pop();
      end
      check("tail_a", asciiChar, 8'h61);
      pop();
      check("drained", {7'b0, asciiValid}, 8'h00);

      send(8'h12);
      send(8'hF0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("midrst");
      rst = 1'b0;
      send(8'h1C);
      check("post_rst_valid", {7'b0, asciiValid}, 8'h01);
      check("post_rst_char", asciiChar, 8'h61);
      pop();

`ifdef PS2_SCANCODE_DECODER_CAPS_LOCK_EN
      send(8'h58);
      check("caps_nochar", {7'b0, asciiValid}, 8'h00);
      send(8'h1C);
      check("caps_A", asciiChar, 8'h41);
      pop();
      send(8'h12); send(8'h1C);
      check("caps_shift_a", asciiChar, 8'h61);
      pop();
      send(8'hF0); send(8'h12);
      send(8'h45);
      check("caps_digit", asciiChar, 8'h30);
      pop();
`else
      send(8'h58);
      check("nocaps_drop", {7'b0, asciiValid}, 8'h00);
      send(8'h1C);
      check("nocaps_a", asciiChar, 8'h61);
      pop();
`endif
      check("final_empty", {7'b0, asciiValid}, 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard receiver and consumes its byte stream (scanCode plus the one-cycle scanCodeReady pulse).
- Interprets Set 2 prefixes (E0 extended, F0 break) and tracks Shift state.
- Translates make codes of printable keys to ASCII and buffers them in a small FIFO with a valid/ready output handshake for the CPU/console side.

Parameters:
- FIFO_DEPTH, 8: number of ASCII entries buffered. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- scanCode  input  8  scan code byte from the receiver; valid while scanCodeReady=1.
- scanCodeReady  input  1  single-cycle strobe: one new byte.
- asciiChar  output  8  head-of-FIFO ASCII character.
- asciiValid  output  1  FIFO not empty.
- asciiReady  input  1  consumer accepts the head entry when asciiValid&&asciiReady.
- shiftHeld  output  1  1 while either Shift key is held.
- overflow  output  1  sticky: a character was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at posedge clk):
  - prefix FSM returns to IDLE;
  - shift flags clear;
  - FIFO empties;
  - outputs: asciiChar=0x00, asciiValid=0, shiftHeld=0, overflow=0.
  - Reset mid-sequence, e.g. after F0, discards the pending prefix.
- A byte is consumed only on cycles with scanCodeReady=1. With scanCodeReady=0 the FSM and FIFO write side hold.
- Prefix FSM states: IDLE, EXT (seen E0), BRK (seen F0), EXT_BRK (seen E0 F0). On each consumed byte:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte = make code, processed, stay IDLE.
  - EXT: F0 -> EXT_BRK; any other byte = extended make, discarded -> IDLE.
  - BRK: byte = break code, processed -> IDLE.
  - EXT_BRK: byte = extended break, discarded -> IDLE.
  - E0 received in BRK or EXT_BRK is treated as a code byte, not a prefix.
- Shift tracking:
  - make 0x12 sets lshift; make 0x59 sets rshift; breaks clear them.
  - shiftHeld = lshift | rshift, registered, updated the cycle after the code byte.
- Make-code map (unshifted -> shifted); breaks of non-shift keys are ignored:
  - letters a-z -> 0x61-0x7A, or 0x41-0x5A when shifted. Codes a..z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - digits 0-9 -> 0x30-0x39 regardless of shift. Codes 0..9: 45 16 1E 26 25 2E 36 3D 3E 46.
  - 0x29 space -> 0x20; 0x5A Enter -> 0x0D; 0x66 Backspace -> 0x08.
  - All other make codes are dropped silently.
  - Repeated makes (typematic) each push a character.
- FIFO:
  - Write occurs on the same posedge scanCodeReady is sampled, so asciiValid rises the following cycle (latency 1).
  - asciiChar is first-word-fall-through: it shows the head whenever asciiValid=1, else 0x00.
  - Pop on asciiValid&&asciiReady.
  - Full with no pop: push is dropped and overflow is set until rst.
  - Full with pop in the same cycle: push is accepted and occupancy is unchanged.
  - Empty with push: asciiValid=1 next cycle; asciiReady while empty has no effect.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; a count register of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.

Optional Feature:
- Macro: PS2_SCANCODE_DECODER_CAPS_LOCK_EN.
- Defined:
  - make 0x58 toggles an internal capsLock flag, cleared by rst;
  - letter case = shifted XOR capsLock;
  - digits are unaffected.
- Undefined: 0x58 is an unmapped code, dropped, and letter case depends on Shift only.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> exactly one entry 0x61; asciiValid=1 one cycle after the 1C strobe; pop with asciiReady=1 -> asciiValid=0.
- 12, 1C, F0 1C, F0 12, 1C -> entries 0x41 then 0x61; shiftHeld 1 after the first byte, 0 after F0 12.
- E0 75, E0 F0 75, then 29 -> only 0x20 queued; FSM back in IDLE; nothing extra is queued from the extended make or break.
- With asciiReady=0, push FIFO_DEPTH+1 makes of 16 -> FIFO_DEPTH entries of 0x31; overflow=1; then push while popping on a full FIFO -> occupancy unchanged, new entry at tail.
- F0 then rst mid-sequence, then 1C -> 0x61 queued (break prefix discarded); all outputs zero during reset.
- With CAPS_LOCK_EN defined: 58, 1C -> 0x41; then 12, 1C -> 0x61.
